ap_hs_initiator: RTL and testbench

- Drives an ap_ctrl_hs callee, such as the SIMD-adder RTL blackbox, from the initiator side.
- Accepts operand vectors on an upstream valid/ready stream, then runs the start/ready/done/continue handshake with the callee.
- Captures the callee's vld-qualified outputs and returns them on a downstream valid/ready stream with error flags.
- Sits between the HLS-side datapath and the blackbox callee; adds a watchdog and a drain phase for callees that hold done high for several cycles.

---
 rtl/ap_hs_pkg.sv | 33 +++
 rtl/ap_hs_initiator_watchdog.sv | 43 ++++
 rtl/ap_hs_initiator.sv | 187 ++++++++++++++++++
 tb/tb_ap_hs_initiator.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_hs_pkg.sv
// ---------------------------------------------------------------------------
// ap_hs_pkg
// Shared definitions for the ap_ctrl_hs initiator: FSM state encoding,
// positions of the error flags in m_err, default lane geometry and a
// lane-slice helper for packed lane vectors.
// ---------------------------------------------------------------------------
package ap_hs_pkg;

  // Initiator FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    OUT   = 2'd2,
    DRAIN = 2'd3
  } hs_state_e;

  // Bit positions inside m_err
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_VLD     = 1;

  // Default lane geometry (matches the SIMD-adder callee)
  localparam int LANE_DW   = 10;
  localparam int NUM_LANES = 4;

  // Extract lane idx from a packed lane vector (lane i at [i*DW +: DW])
  function automatic logic [LANE_DW-1:0] lane_slice(
    input logic [NUM_LANES*LANE_DW-1:0] bus,
    input int                           idx
  );
    return bus[idx*LANE_DW +: LANE_DW];
  endfunction

endpackage

// File: rtl/ap_hs_initiator_watchdog.sv
// ---------------------------------------------------------------------------
// ap_hs_watchdog
// Counts cycles while enabled and flags the cycle in which the count
// reaches the limit, so the caller can abort on that same edge.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : zero the counter (has priority over i_enable)
//   i_enable     : count this cycle
//   i_limit      : number of enabled cycles allowed
//   o_expired    : high in the enabled cycle that reaches i_limit
// ---------------------------------------------------------------------------
module ap_hs_watchdog #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_inc;

  // One extra bit so the comparison cannot wrap at the all-ones count
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);

  // Expire in the enabled cycle whose increment reaches the limit, so a
  // limit of N allows exactly N enabled cycles
  assign o_expired = i_enable && (w_cnt_inc >= {1'b0, i_limit});

  // Cycle counter: cleared on request, saturates instead of wrapping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != '1)) begin
      r_cnt <= w_cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/ap_hs_initiator.sv
// ---------------------------------------------------------------------------
// ap_hs_initiator
// Initiator side of an ap_ctrl_hs handshake. Takes operand vectors from an
// upstream valid/ready stream, runs start/ready/done/continue with the
// callee, and returns the captured results with error flags downstream.
//   ap_clk, ap_rst        : clock, asynchronous active-high reset
//   s_valid/s_ready       : upstream operand stream, s_a/s_b packed lanes
//   m_valid/m_ready       : downstream result stream, m_z lanes, m_err flags
//                           (bit0 timeout, bit1 lane vld mismatch)
//   c_start/c_continue/c_ce, c_a/c_b : drive to the callee
//   c_idle/c_ready/c_done, c_z/c_z_vld : status and results from the callee
//   busy                  : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module ap_hs_initiator
  import ap_hs_pkg::*;
#(
  parameter int DW      = LANE_DW,
  parameter int LANES   = NUM_LANES,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [LANES*DW-1:0] s_a,
  input  logic [LANES*DW-1:0] s_b,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [LANES*DW-1:0] m_z,
  output logic [1:0]          m_err,
  output logic                c_start,
  output logic                c_continue,
  output logic                c_ce,
  output logic [LANES*DW-1:0] c_a,
  output logic [LANES*DW-1:0] c_b,
  input  logic                c_idle,
  input  logic                c_ready,
  input  logic                c_done,
  input  logic [LANES*DW-1:0] c_z,
  input  logic [LANES-1:0]    c_z_vld,
  output logic                busy
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  hs_state_e           r_state, w_state_nxt;
  logic                r_s_ready, w_s_ready_nxt;
  logic                r_m_valid, w_m_valid_nxt;
  logic [LANES*DW-1:0] r_m_z, w_m_z_nxt;
  logic [1:0]          r_m_err, w_m_err_nxt;
  logic                r_c_start, w_c_start_nxt;
  logic                r_c_continue, w_c_continue_nxt;
  logic                r_c_ce;
  logic [LANES*DW-1:0] r_a, w_a_nxt;
  logic [LANES*DW-1:0] r_b, w_b_nxt;
  logic                r_busy;
  logic                w_accept;
  logic                w_wd_enable;
  logic                w_wd_expired;
  logic                w_unused_idle;

  // ap_idle is informational only; nothing in the handshake depends on it
  assign w_unused_idle = c_idle;

  assign w_accept    = (r_state == IDLE) && s_valid && r_s_ready;
  assign w_wd_enable = (r_state == START);

  // Watchdog counts START cycles and is rearmed on every accepted operand
  ap_hs_watchdog #(
    .CNT_W(CNT_W)
  ) u_watchdog (
    .i_clk    (ap_clk),
    .i_rst    (ap_rst),
    .i_clear  (w_accept),
    .i_enable (w_wd_enable),
    .i_limit  (LIMIT),
    .o_expired(w_wd_expired)
  );

  // Next-state and next-output logic. Every output is a register, so this
  // block computes the value each register takes at the next edge. Done has
  // priority over the watchdog and over ready: a callee may raise ready and
  // done together, and only done completes the call.
  always_comb begin
    w_state_nxt      = r_state;
    w_s_ready_nxt    = 1'b0;
    w_m_valid_nxt    = r_m_valid;
    w_m_z_nxt        = r_m_z;
    w_m_err_nxt      = r_m_err;
    w_c_start_nxt    = 1'b0;
    w_c_continue_nxt = 1'b0;
    w_a_nxt          = r_a;
    w_b_nxt          = r_b;

    unique case (r_state)
      IDLE: begin
        w_s_ready_nxt = 1'b1;
        if (w_accept) begin
          w_a_nxt       = s_a;
          w_b_nxt       = s_b;
          w_s_ready_nxt = 1'b0;
          w_c_start_nxt = 1'b1;
          w_state_nxt   = START;
        end
      end
      START: begin
        if (c_done) begin
          w_m_z_nxt              = c_z;
          w_m_err_nxt            = '0;
          w_m_err_nxt[ERR_VLD]   = ~&c_z_vld;
          w_m_valid_nxt          = 1'b1;
          w_c_continue_nxt       = 1'b1;
          w_state_nxt            = OUT;
        end else if (w_wd_expired) begin
          w_m_z_nxt                = '0;
          w_m_err_nxt              = '0;
          w_m_err_nxt[ERR_TIMEOUT] = 1'b1;
          w_m_valid_nxt            = 1'b1;
          w_state_nxt              = OUT;
        end else begin
          w_c_start_nxt = 1'b1;
        end
      end
      OUT: begin
        if (r_m_valid && m_ready) begin
          w_m_valid_nxt = 1'b0;
          w_m_err_nxt   = '0;
          w_state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        // A callee may hold done for several cycles; wait until both done
        // and ready are low so the next call cannot see a stale done
        if (!c_done && !c_ready) begin
          w_s_ready_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers. Reset discards any call in flight; clock
  // enable to the callee is held high from the first edge after reset.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state      <= IDLE;
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_z        <= '0;
      r_m_err      <= '0;
      r_c_start    <= 1'b0;
      r_c_continue <= 1'b0;
      r_c_ce       <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_s_ready    <= w_s_ready_nxt;
      r_m_valid    <= w_m_valid_nxt;
      r_m_z        <= w_m_z_nxt;
      r_m_err      <= w_m_err_nxt;
      r_c_start    <= w_c_start_nxt;
      r_c_continue <= w_c_continue_nxt;
      r_c_ce       <= 1'b1;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_z        = r_m_z;
  assign m_err      = r_m_err;
  assign c_start    = r_c_start;
  assign c_continue = r_c_continue;
  assign c_ce       = r_c_ce;
  assign c_a        = r_a;
  assign c_b        = r_b;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ap_hs_initiator.sv
// ---------------------------------------------------------------------------
// tb_ap_hs_initiator
// Drives ap_hs_initiator against a 2-stage SIMD-adder callee model with
// selectable behaviour (normal, lane vld mismatch, done held after
// continue, never done). Expected responses come from a transaction-level
// model: lane sums modulo 2^DW, error flags and handshake counts per call.
// ---------------------------------------------------------------------------
module tb_ap_hs_initiator;
  import ap_hs_pkg::*;

  localparam int DW      = LANE_DW;
  localparam int LANES   = NUM_LANES;
  localparam int BUS     = DW * LANES;
  localparam int TIMEOUT = 8;

  localparam int M_NORMAL = 0;
  localparam int M_VLD    = 1;
  localparam int M_HOLD   = 2;
  localparam int M_NEVER  = 3;

  typedef struct {
    logic [BUS-1:0] z;
    logic [1:0]     err;
    int             cs;
    int             cont;
  } exp_t;

  typedef struct {
    int             mode;
    logic [LANES-1:0] vld;
    int             hold;
  } cfg_t;

  logic             ap_clk, ap_rst;
  logic             s_valid, s_ready;
  logic [BUS-1:0]   s_a, s_b;
  logic             m_valid, m_ready;
  logic [BUS-1:0]   m_z;
  logic [1:0]       m_err;
  logic             c_start, c_continue, c_ce;
  logic [BUS-1:0]   c_a, c_b;
  logic             c_idle, c_ready, c_done;
  logic [BUS-1:0]   c_z;
  logic [LANES-1:0] c_z_vld;
  logic             busy;

  exp_t expQ[$];
  cfg_t cfgQ[$];
  cfg_t drvCfg;
  int   checks = 0;
  int   errors = 0;
  int   mrMode = 0;
  int   respCount = 0;

  logic [BUS-1:0] lastZ;
  logic [1:0]     lastErr;
  int             lastCs, lastCont, lastLat;

  ap_hs_initiator #(
    .DW(DW), .LANES(LANES), .TIMEOUT(TIMEOUT), .CNT_W(8)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z), .m_err(m_err),
    .c_start(c_start), .c_continue(c_continue), .c_ce(c_ce),
    .c_a(c_a), .c_b(c_b), .c_idle(c_idle), .c_ready(c_ready),
    .c_done(c_done), .c_z(c_z), .c_z_vld(c_z_vld), .busy(busy)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // One comparison: counted, and reported when it does not hold
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Transaction-level expectation for one accepted operand pair
  function automatic exp_t modelResult(input logic [BUS-1:0] a,
                                       input logic [BUS-1:0] b,
                                       input cfg_t c);
    exp_t e;
    e.z   = '0;
    e.err = '0;
    if (c.mode == M_NEVER) begin
      e.err[ERR_TIMEOUT] = 1'b1;
      e.cs   = TIMEOUT;
      e.cont = 0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        int sum;
        sum = int'(lane_slice(a, i)) + int'(lane_slice(b, i));
        e.z[i*DW +: DW] = DW'(sum % (1 << DW));
      end
      e.err[ERR_VLD] = (c.vld != '1);
      e.cs   = 3;
      e.cont = 1;
    end
    return e;
  endfunction

  // Offer one operand pair and hold it until the DUT takes it
  task automatic applyStimulus(input logic [BUS-1:0] a, input logic [BUS-1:0] b,
                               input int mode, input logic [LANES-1:0] vld,
                               input int hold);
    bit accepted;
    accepted = 0;
    drvCfg   = '{mode, vld, hold};
    s_a      = a;
    s_b      = b;
    s_valid  = 1'b1;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge ap_clk);
      if (s_ready && !ap_rst) accepted = 1;
    end
    @(posedge ap_clk);
    #1;
    s_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 0, 1);
  endtask

  // Wait until every expected response is out and the DUT is back in IDLE
  task automatic waitIdle();
    bit idle;
    idle = 0;
    for (int k = 0; k < 600 && !idle; k++) begin
      @(negedge ap_clk);
      if (!busy && expQ.size() == 0 && !s_valid) idle = 1;
    end
    if (!idle) checkOutput("idle_timeout", 0, 1);
    @(posedge ap_clk);
    #1;
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = held low
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge ap_clk);
      #1;
      case (mrMode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Callee model: 2-stage adder with ap_ctrl_hs semantics. Samples the
  // initiator at the falling edge and updates just after the rising edge.
  initial begin
    logic           smpStart, smpCont, cbBusy, cbIgn, cbRel;
    logic [BUS-1:0] smpA, smpB, cbZ;
    logic [LANES-1:0] cbVld;
    int             cbHold;
    cfg_t           cc;
    c_done = 0; c_ready = 0; c_z = '0; c_z_vld = '0; c_idle = 1;
    cbBusy = 0; cbIgn = 0; cbRel = 0; cbHold = 0; cbZ = '0; cbVld = '0;
    forever begin
      @(negedge ap_clk);
      smpStart = c_start;
      smpCont  = c_continue;
      smpA     = c_a;
      smpB     = c_b;
      @(posedge ap_clk);
      #1;
      if (ap_rst) begin
        c_done = 0; c_ready = 0; c_z_vld = '0;
        cbBusy = 0; cbIgn = 0; cbRel = 0; cbHold = 0;
      end else begin
        c_ready = 0;
        if (cbIgn) begin
          if (!smpStart) cbIgn = 0;
        end else if (cbBusy) begin
          c_done  = 1;
          c_z     = cbZ;
          c_z_vld = cbVld;
          cbBusy  = 0;
        end else if (c_done) begin
          if (cbRel || smpCont) begin
            cbRel = 1;
            if (cbHold == 0) begin
              c_done  = 0;
              c_z_vld = '0;
              c_z     = BUS'({$urandom(), $urandom()});
              cbRel   = 0;
            end else begin
              cbHold--;
            end
          end
        end else if (smpStart && cfgQ.size() > 0) begin
          cc = cfgQ.pop_front();
          if (cc.mode == M_NEVER) begin
            cbIgn = 1;
          end else begin
            for (int i = 0; i < LANES; i++)
              cbZ[i*DW +: DW] = smpA[i*DW +: DW] + smpB[i*DW +: DW];
            cbVld   = (cc.mode == M_VLD) ? cc.vld : '1;
            cbHold  = (cc.mode == M_HOLD) ? cc.hold : 0;
            cbBusy  = 1;
            c_ready = 1;
          end
        end
      end
      c_idle = !(cbBusy || c_done || cbIgn);
    end
  end

  // Monitor and compare: records each accepted call into the model queues
  // and checks every response plus the per-cycle output rules
  initial begin
    bit             active, seenV, prevHold;
    int             trkCs, trkCont, trkLat;
    logic [BUS-1:0] curA, curB, holdZ;
    logic [1:0]     holdErr;
    exp_t           e;
    active = 0; seenV = 0; prevHold = 0;
    trkCs = 0; trkCont = 0; trkLat = 0;
    curA = '0; curB = '0; holdZ = '0; holdErr = '0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst) begin
        active   = 0;
        prevHold = 0;
      end else begin
        if (active) begin
          if (c_start) trkCs++;
          if (c_continue) trkCont++;
          if (!seenV) begin
            trkLat++;
            if (m_valid) seenV = 1;
          end
        end
        checkOutput("c_ce_high", c_ce, 1);
        if (prevHold) begin
          checkOutput("held_valid", m_valid, 1);
          checkOutput("held_z", m_z, holdZ);
          checkOutput("held_err", m_err, holdErr);
        end
        if (m_valid) checkOutput("s_ready_while_result", s_ready, 0);
        if (s_ready) checkOutput("busy_while_ready", busy, 0);
        if (c_start) begin
          checkOutput("c_a_stable", c_a, curA);
          checkOutput("c_b_stable", c_b, curB);
        end
        if (m_valid && m_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("spurious_response", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("resp_z", m_z, e.z);
            checkOutput("resp_err", m_err, e.err);
            checkOutput("resp_start_cycles", trkCs, e.cs);
            checkOutput("resp_continue_pulses", trkCont, e.cont);
          end
          lastZ = m_z; lastErr = m_err;
          lastCs = trkCs; lastCont = trkCont; lastLat = trkLat;
          respCount++;
          active   = 0;
          prevHold = 0;
        end else if (m_valid) begin
          prevHold = 1;
          holdZ    = m_z;
          holdErr  = m_err;
        end else begin
          prevHold = 0;
        end
        if (s_valid && s_ready) begin
          expQ.push_back(modelResult(s_a, s_b, drvCfg));
          cfgQ.push_back(drvCfg);
          curA = s_a; curB = s_b;
          active = 1; seenV = 0;
          trkCs = 0; trkCont = 0; trkLat = 0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  // Main sequence
  initial begin
    logic [BUS-1:0] aBasic, bBasic, zBasic, aWrap, bWrap, ra, rb;
    logic [LANES-1:0] rv;
    int snap, r, mode, hold;
    aBasic = {10'd4, 10'd3, 10'd2, 10'd1};
    bBasic = {10'd40, 10'd30, 10'd20, 10'd10};
    zBasic = {10'd44, 10'd33, 10'd22, 10'd11};
    aWrap  = {10'd7, 10'd6, 10'd5, 10'd1023};
    bWrap  = {10'd1, 10'd1, 10'd1, 10'd1};
    ap_rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0;
    drvCfg = '{M_NORMAL, '1, 0};

    #12;
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_z", m_z, 0);
    checkOutput("rst_m_err", m_err, 0);
    checkOutput("rst_c_start", c_start, 0);
    checkOutput("rst_c_continue", c_continue, 0);
    checkOutput("rst_c_ce", c_ce, 0);
    checkOutput("rst_c_a", c_a, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge ap_clk);
    #1 ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    checkOutput("post_rst_c_ce", c_ce, 1);
    checkOutput("post_rst_s_ready", s_ready, 1);

    $display("[TB] basic");
    applyStimulus(aBasic, bBasic, M_NORMAL, '1, 0);
    waitIdle();
    checkOutput("basic_z", lastZ, zBasic);
    checkOutput("basic_err", lastErr, 2'b00);
    checkOutput("basic_start_cycles", lastCs, 3);
    checkOutput("basic_valid_latency", lastLat, 4);
    checkOutput("basic_continue", lastCont, 1);

    $display("[TB] wrap");
    applyStimulus(aWrap, bWrap, M_NORMAL, '1, 0);
    waitIdle();
    checkOutput("wrap_lane0", lane_slice(lastZ, 0), 0);
    checkOutput("wrap_z", lastZ, {10'd8, 10'd7, 10'd6, 10'd0});
    checkOutput("wrap_err", lastErr, 2'b00);

    $display("[TB] timeout");
    applyStimulus(aBasic, bBasic, M_NEVER, '1, 0);
    waitIdle();
    checkOutput("timeout_z", lastZ, 0);
    checkOutput("timeout_err", lastErr, 2'b01);
    checkOutput("timeout_start_cycles", lastCs, 8);
    checkOutput("timeout_valid_latency", lastLat, 9);
    checkOutput("timeout_continue", lastCont, 0);
    checkOutput("timeout_back_idle", s_ready, 1);

    $display("[TB] vld mismatch");
    applyStimulus(aBasic, bBasic, M_VLD, 4'b1011, 0);
    waitIdle();
    checkOutput("vld_err", lastErr, 2'b10);
    checkOutput("vld_z", lastZ, zBasic);

    $display("[TB] backpressure");
    snap = respCount;
    mrMode = 2;
    applyStimulus(aBasic, bBasic, M_NORMAL, '1, 0);
    fork
      applyStimulus(aWrap, bWrap, M_HOLD, '1, 3);
      begin
        for (int k = 0; k < 50 && !m_valid; k++) @(negedge ap_clk);
        repeat (5) @(negedge ap_clk);
        checkOutput("bp_valid_held", m_valid, 1);
        checkOutput("bp_s_ready_low", s_ready, 0);
        @(posedge ap_clk);
        #1 mrMode = 0;
      end
    join
    waitIdle();
    checkOutput("bp_two_responses", respCount - snap, 2);
    checkOutput("bp_second_z", lastZ, {10'd8, 10'd7, 10'd6, 10'd0});

    $display("[TB] held done back-to-back");
    snap = respCount;
    applyStimulus(aBasic, bBasic, M_HOLD, '1, 4);
    applyStimulus(aWrap, bWrap, M_HOLD, '1, 2);
    waitIdle();
    checkOutput("hold_two_responses", respCount - snap, 2);

    $display("[TB] reset mid-op");
    snap = respCount;
    applyStimulus(aBasic, bBasic, M_NEVER, '1, 0);
    @(posedge ap_clk);
    #3 ap_rst = 1'b1;
    #1;
    checkOutput("midrst_c_start", c_start, 0);
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_s_ready", s_ready, 0);
    checkOutput("midrst_c_a", c_a, 0);
    expQ.delete();
    cfgQ.delete();
    repeat (2) @(negedge ap_clk);
    #1 ap_rst = 1'b0;
    repeat (5) @(posedge ap_clk);
    #1;
    checkOutput("midrst_no_response", respCount - snap, 0);
    applyStimulus(aBasic, bBasic, M_NORMAL, '1, 0);
    waitIdle();
    checkOutput("midrst_next_z", lastZ, zBasic);
    checkOutput("midrst_next_count", respCount - snap, 1);

    $display("[TB] random");
    mrMode = 1;
    for (int t = 0; t < 40; t++) begin
      r    = $urandom_range(0, 7);
      mode = (r < 3) ? M_NORMAL : (r < 5) ? M_VLD : (r < 7) ? M_HOLD : M_NEVER;
      rv   = (mode == M_VLD) ? LANES'($urandom_range(0, 14)) : '1;
      hold = (mode == M_HOLD) ? $urandom_range(1, 4) : 0;
      ra   = BUS'({$urandom(), $urandom()});
      rb   = BUS'({$urandom(), $urandom()});
      applyStimulus(ra, rb, mode, rv, hold);
    end
    waitIdle();
    mrMode = 0;
    checkOutput("queue_empty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
